// File: rtl/alu_seq_hs.sv
// Handshaked signed ALU: single-cycle ADD/SUB/MULT, iterative restoring DIV with
// remainder and error flag; full 2*WIDTH result so no operation can overflow.
package alu_seq_pkg;
    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MULT = 3'd2,
        DIV  = 3'd3
    } opcode_e;
endpackage

module alu_seq_hs
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] operand1,
    input  logic signed [WIDTH-1:0] operand2,
    input  opcode_e                 opcode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [RES_W-1:0] out,
    output logic signed [WIDTH-1:0] rem,
    output logic                    err
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2,
        HOLD     = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic signed [RES_W-1:0] out_q, out_d;
    logic signed [WIDTH-1:0] rem_q, rem_d;
    logic                    err_q, err_d;
    logic                    out_valid_q, out_valid_d;

    // Divider working set: magnitudes of dividend/divisor, partial remainder,
    // quotient being assembled MSB first, and the signs to restore at the end.
    logic [WIDTH-1:0]        dvd_q, dvd_d;
    logic [WIDTH-1:0]        dvs_q, dvs_d;
    logic [WIDTH-1:0]        prem_q, prem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    neg_quo_q, neg_quo_d;
    logic                    neg_rem_q, neg_rem_d;

    logic                    accept;
    logic signed [RES_W-1:0] a_ext, b_ext;
    logic [WIDTH-1:0]        abs1, abs2;
    logic [WIDTH:0]          trial;
    logic                    q_bit;
    logic [RES_W-1:0]        quo_ext;

    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        rem_d       = rem_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;

        a_ext   = RES_W'(operand1);
        b_ext   = RES_W'(operand2);
        abs1    = operand1[WIDTH-1] ? $unsigned(-operand1) : $unsigned(operand1);
        abs2    = operand2[WIDTH-1] ? $unsigned(-operand2) : $unsigned(operand2);
        trial   = {prem_q, dvd_q[WIDTH-1]};
        q_bit   = (trial >= {1'b0, dvs_q});
        quo_ext = RES_W'(quo_q);

        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                if (accept) begin
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    rem_d       = '0;
                    err_d       = 1'b0;
                    case (opcode)
                        ADD:  out_d = a_ext + b_ext;
                        SUB:  out_d = a_ext - b_ext;
                        MULT: out_d = a_ext * b_ext;
                        DIV: begin
                            if (operand2 == '0) begin
                                out_d = '0;
                                err_d = 1'b1;
                            end else begin
                                dvd_d       = abs1;
                                dvs_d       = abs2;
                                prem_d      = '0;
                                quo_d       = '0;
                                cnt_d       = '0;
                                neg_quo_d   = operand1[WIDTH-1] ^ operand2[WIDTH-1];
                                neg_rem_d   = operand1[WIDTH-1];
                                out_valid_d = 1'b0;
                                state_d     = DIV_BUSY;
                            end
                        end
                        default: begin
                            out_d = '0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            DIV_BUSY: begin
                // Partial remainder stays below the divisor, so WIDTH bits hold it.
                prem_d = q_bit ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
                quo_d  = {quo_q[WIDTH-2:0], q_bit};
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                out_d       = neg_quo_q ? -quo_ext : quo_ext;
                rem_d       = neg_rem_q ? -prem_q : prem_q;
                err_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
        end
    end

    assign out       = out_q;
    assign rem       = rem_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Directed plus random checks of alu_seq_hs against an integer-arithmetic model.
module tb_alu_seq_hs;
    import alu_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int RES_W = 2 * WIDTH;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] operand1;
    logic signed [WIDTH-1:0] operand2;
    opcode_e                 opcode;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [RES_W-1:0] out;
    logic signed [WIDTH-1:0] rem;
    logic                    err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_hs #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .rem(rem), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; SV int division truncates toward zero
    // and the remainder takes the sign of the dividend.
    task automatic model(input opcode_e op, input int a, input int b,
                         output int e_out, output int e_rem, output int e_err,
                         output int e_lat);
        e_out = 0; e_rem = 0; e_err = 0; e_lat = 1;
        case (op)
            ADD:  e_out = a + b;
            SUB:  e_out = a - b;
            MULT: e_out = a * b;
            DIV: begin
                if (b == 0) e_err = 1;
                else begin
                    e_out = a / b;
                    e_rem = a % b;
                    e_lat = WIDTH + 2;
                end
            end
            default: e_err = 1;
        endcase
    endtask

    task automatic run_op(input string tag, input opcode_e op,
                          input logic signed [WIDTH-1:0] a,
                          input logic signed [WIDTH-1:0] b);
        int w, lat, e_out, e_rem, e_err, e_lat;
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) check({tag, "_ready_timeout"}, in_ready, 1);
        opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        operand1 = WIDTH'($urandom);
        operand2 = WIDTH'($urandom);
        opcode   = ADD;
        lat = 1;
        while (!out_valid && lat < WIDTH + 8) begin
            tick();
            lat++;
        end
        model(op, int'(a), int'(b), e_out, e_rem, e_err, e_lat);
        $display("op %0d a=%0d b=%0d -> out=%0d rem=%0d err=%0d lat=%0d",
                 op, a, b, out, rem, err, lat);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_out"}, out, e_out);
        check({tag, "_rem"}, rem, e_rem);
        check({tag, "_err"}, err, e_err);
    endtask

    initial begin
        int e_out, e_rem, e_err, e_lat;
        int saw_valid;
        logic [2:0] r;
        logic signed [WIDTH-1:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        operand1 = '0; operand2 = '0; opcode = ADD;
        tick(); tick();
        rst = 1'b0;
        check("rst_out", out, 0);
        check("rst_rem", rem, 0);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);

        // Back-to-back single-cycle ops
        in_valid = 1'b1; opcode = ADD; operand1 = 8'sd127; operand2 = 8'sd127;
        tick();
        check("b2b_add", out, 254);
        check("b2b_add_v", out_valid, 1);
        check("b2b_rdy", in_ready, 1);
        opcode = SUB; operand1 = -8'sd128; operand2 = 8'sd1;
        tick();
        check("b2b_sub", out, -129);
        opcode = MULT; operand1 = -8'sd128; operand2 = -8'sd128;
        tick();
        check("b2b_mult", out, 16384);
        check("b2b_err", err, 0);
        in_valid = 1'b0;
        $display("b2b done out=%0d", out);
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_hold", out, 16384);

        // DIV -7/2 with explicit cycle-by-cycle busy check
        in_valid = 1'b1; opcode = DIV; operand1 = -8'sd7; operand2 = 8'sd2;
        tick();
        in_valid = 1'b0; operand1 = 8'sd99; operand2 = 8'sd0; opcode = SUB;
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("div_busy_rdy_c%0d", i), in_ready, 0);
            check($sformatf("div_busy_v_c%0d", i), out_valid, 0);
            tick();
        end
        $display("div -7/2 cycle10 out=%0d rem=%0d valid=%0d", out, rem, out_valid);
        check("div_c10_valid", out_valid, 1);
        check("div_out", out, -3);
        check("div_rem", rem, -1);
        check("div_err", err, 0);

        run_op("div_minneg", DIV, -8'sd128, -8'sd1);
        run_op("div_zero", DIV, 8'sd5, 8'sd0);
        run_op("after_dz_add", ADD, 8'sd1, 8'sd1);
        run_op("illegal", opcode_e'(3'd6), 8'sd9, 8'sd3);

        // Backpressure then no-bubble handover
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b1; opcode = MULT; operand1 = 8'sd3; operand2 = 8'sd4;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_out_%0d", i), out, 12);
            check($sformatf("bp_v_%0d", i), out_valid, 1);
            check($sformatf("bp_rdy_%0d", i), in_ready, 0);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b1; opcode = ADD; operand1 = 8'sd1; operand2 = 8'sd2;
        #1;
        check("handover_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        $display("handover out=%0d valid=%0d", out, out_valid);
        check("handover_out", out, 3);
        check("handover_v", out_valid, 1);

        // Reset in cycle 4 of DIV 100/3
        in_valid = 1'b1; opcode = DIV; operand1 = 8'sd100; operand2 = 8'sd3;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", out, 0);
        saw_valid = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) saw_valid = 1;
            tick();
        end
        $display("abort saw_valid=%0d in_ready=%0d", saw_valid, in_ready);
        check("abort_no_valid", saw_valid, 0);
        check("abort_idle", in_ready, 1);
        run_op("div_100_3", DIV, 8'sd100, 8'sd3);

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            r = 3'($urandom_range(0, 4));
            if (r == 3'd4) r = 3'd7;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            run_op($sformatf("rand%0d", n), opcode_e'(r), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq_hs.md
Name: alu_seq_hs

Overview:
- Parametrised, handshaked successor to the single-cycle sequential ALU.
- Operates on signed WIDTH-bit operands with the package opcode_e set (ADD, SUB, MULT, DIV).
- Uses valid/ready flow control on input and output, and a full-width result so nothing overflows.
- DIV is iterative (one quotient bit per cycle) and adds a remainder output plus an error flag. Sits between a stimulus/command source and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- RES_W, 2*WIDTH, result width; fixed by WIDTH, not overridden.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  operand/opcode bundle valid
- in_ready  out  1  block can accept a bundle
- operand1  in  WIDTH  signed first operand (dividend for DIV)
- operand2  in  WIDTH  signed second operand (divisor for DIV)
- opcode  in  opcode_e  operation (enum from alu_seq_pkg)
- out_valid  out  1  result bundle valid
- out_ready  in  1  consumer accepts the result
- out  out  RES_W  signed result; quotient for DIV
- rem  out  WIDTH  signed remainder for DIV; 0 for other ops
- err  out  1  error: DIV by zero or illegal opcode

Behaviour:
- Reset: rst=1 at a posedge forces FSM to IDLE and sets out=0, rem=0, err=0, out_valid=0. The divider counter and working registers are cleared. Reset overrides all other activity, including aborting a DIV mid-iteration; the aborted result is never presented.
- FSM states:
  - IDLE: no result pending.
  - DIV_BUSY: iterating.
  - DIV_FIX: sign correction and output write.
  - HOLD: out_valid=1, waiting for out_ready.
- in_ready = (state==IDLE) or (state==HOLD and out_ready). Accept = in_valid & in_ready; this allows back-to-back throughput of 1 per cycle for non-DIV ops.
- ADD/SUB/MULT on accept: out <= sign-extended operand1 op operand2, computed in RES_W bits; rem<=0, err<=0, out_valid<=1, state->HOLD. Latency: accept in cycle 0, result visible in cycle 1.
- DIV, divisor != 0:
  - Accept edge loads |operand1|, |operand2| and the result signs, and clears counter; state->DIV_BUSY.
  - WIDTH restoring-division iterations, one per cycle, counter 0..WIDTH-1.
  - On the last iteration, state->DIV_FIX.
  - DIV_FIX edge writes out = quotient, sign-extended to RES_W, truncated toward zero. rem takes the sign of the dividend. Then out_valid<=1, err<=0, state->HOLD.
  - Latency: accept cycle 0, out_valid visible in cycle WIDTH+2.
  - Most-negative / -1 (e.g. -128/-1 at WIDTH=8) gives +128 in RES_W; no overflow.
- DIV by zero: handled at the accept edge like a 1-cycle op; out=0, rem=0, err=1, out_valid=1.
- Opcode outside {ADD,SUB,MULT,DIV}: 1-cycle, out=0, rem=0, err=1.
- In DIV_BUSY and DIV_FIX: in_ready=0, out_valid=0.
- HOLD:
  - out, rem and err are held stable while out_valid=1 and out_ready=0.
  - out_ready=1 with no new accept: out_valid<=0 and state->IDLE; out/rem/err keep their last values.
  - out_ready=1 with a simultaneous accept: the new op proceeds as from IDLE.
- Operands and opcode are sampled only at the accept edge; later input changes do not affect an in-flight DIV.

Test Plan:
- Reset with in_valid=0 -> out=0, rem=0, err=0, out_valid=0, in_ready=1 in the cycle after reset.
- ADD 127+127, SUB -128-1, MULT -128*-128 at WIDTH=8, back-to-back with out_ready=1 -> out=254, -129, 16384 on consecutive cycles 1,2,3, err=0.
- DIV -7/2 at WIDTH=8 -> out_valid first high in cycle 10, out=-3, rem=-1, err=0. in_ready=0 during cycles 1..9. Also DIV -128/-1 -> out=128.
- DIV 5/0 -> cycle 1: out=0, rem=0, err=1, out_valid=1. Next op ADD 1+1 -> out=2, err=0.
- Backpressure: MULT 3*4 with out_ready=0 for 5 cycles -> out=12 held stable, in_ready=0. Raise out_ready together with in_valid (ADD 1+2) -> handover with no bubble, out=3 next cycle.
- rst asserted in cycle 4 of DIV 100/3 -> out_valid never rises for it, state IDLE. A fresh DIV 100/3 -> out=33, rem=1.
